serial_adder_ctrl: RTL and testbench

Bit-serial adder controller built around a single full_adder instance, which it reuses once per cycle to add two N-bit operands LSB-first. A start/busy/done handshake sequences operand loading, N add cycles and result presentation. It is the area-minimal alternative to an N-bit ripple adder and is the first sequential consumer of full_adder.

---
 rtl/serial_adder_ctrl_pkg.sv | 12 +
 rtl/serial_adder_ctrl_full_adder.sv | 13 +
 rtl/serial_adder_ctrl.sv | 100 ++++++++++
 tb/tb_serial_adder_ctrl.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/serial_adder_ctrl_pkg.sv
// rtl/serial_adder_ctrl_pkg.sv - shared state encodings and width defaults for the serial adder
package serial_adder_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int ADDER_W = 8;

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// rtl/serial_adder_ctrl_full_adder.sv - single-bit combinational full adder
module full_adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);

    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial N-bit adder reusing one full_adder per cycle, LSB first
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int N = ADDER_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] S,
    output logic         Cout
);

    localparam int            CW   = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t          r_state;
    logic [N-1:0]    r_a_sh;
    logic [N-1:0]    r_b_sh;
    logic [N-1:0]    r_s;
    logic            r_carry;
    logic            r_cout;
    logic            r_busy;
    logic            r_done;
    logic [CW-1:0]   r_cnt;

    logic            w_sum;
    logic            w_cout;

    full_adder u_full_adder (
        .A    (r_a_sh[0]),
        .B    (r_b_sh[0]),
        .Cin  (r_carry),
        .S    (w_sum),
        .Cout (w_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_s     <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a_sh  <= A;
                        r_b_sh  <= B;
                        r_carry <= Cin;
                        r_cnt   <= '0;
                        r_s     <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    // Sum bits enter at the MSB so after N shifts bit 0 lands at S[0].
                    r_a_sh  <= {1'b0, r_a_sh[N-1:1]};
                    r_b_sh  <= {1'b0, r_b_sh[N-1:1]};
                    r_s     <= {w_sum, r_s[N-1:1]};
                    r_carry <= w_cout;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_cout  <= w_cout;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign S    = r_s;
    assign Cout = r_cout;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - scoreboard bench for serial_adder_ctrl at N=8 and N=2
module tb_serial_adder_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start8, cin8, start2, cin2;
    logic [7:0] a8, b8;
    logic [1:0] a2, b2;
    wire        busy8, done8, cout8, busy2, done2, cout2;
    wire  [7:0] s8;
    wire  [1:0] s2;

    int         cyc = 0;
    int         n_checks = 0;
    int         n_pass = 0;
    logic [8:0] q8[$];
    logic [2:0] q2[$];
    logic [8:0] last8;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_adder_ctrl #(.N(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .B(b8), .Cin(cin8),
        .busy(busy8), .done(done8), .S(s8), .Cout(cout8)
    );

    serial_adder_ctrl #(.N(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .A(a2), .B(b2), .Cin(cin2),
        .busy(busy2), .done(done2), .S(s2), .Cout(cout2)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (done8) begin
            if (q8.size() == 0) check("done8_unexpected", 1, 0);
            else check("sum8", {cout8, s8}, q8.pop_front());
        end
    end

    always @(negedge clk) begin
        if (done2) begin
            if (q2.size() == 0) check("done2_unexpected", 1, 0);
            else check("sum2", {cout2, s2}, q2.pop_front());
        end
    end

    // Issue one addition, then verify busy length, done latency and single-cycle done.
    task automatic add8(input logic [7:0] a, input logic [7:0] b, input logic cin);
        int e, nb, lat;
        bit got;
        @(posedge clk); #1;
        a8 = a; b8 = b; cin8 = cin; start8 = 1'b1;
        last8 = 9'(a) + 9'(b) + 9'(cin);
        q8.push_back(last8);
        e = cyc;
        @(posedge clk); #1;
        start8 = 1'b0;
        nb = 0; lat = 0; got = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            if (busy8) nb++;
            if (done8) begin got = 1; lat = cyc - e; end
            else begin @(posedge clk); #1; end
        end
        check("done8_timeout", got, 1);
        check("done8_latency", lat, 9);
        check("busy8_cycles", nb, 8);
        @(posedge clk); #1;
        check("done8_single_pulse", done8, 0);
    endtask

    initial begin
        int nd, prev;
        bit got;
        rst_n = 1'b0; start8 = 1'b0; start2 = 1'b0;
        a8 = '0; b8 = '0; cin8 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
        #1;
        check("reset8_outputs", {busy8, done8, cout8, s8}, 0);
        check("reset2_outputs", {busy2, done2, cout2, s2}, 0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        add8(8'h00, 8'h00, 1'b0);
        add8(8'h5A, 8'h33, 1'b1);
        add8(8'hFF, 8'h01, 1'b0);

        // Operands and start churn during ADD must not affect the result or queue a new add.
        @(posedge clk); #1;
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
        last8 = 9'h1FF;
        q8.push_back(last8);
        nd = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (done8) nd++;
            if (busy8) begin
                a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); start8 = 1'b1;
            end else begin
                start8 = 1'b0;
            end
        end
        check("no_extra_done8", nd, 1);

        // Abort at the 4th ADD cycle; three sum bits of 1 have shifted in by then.
        @(posedge clk); #1;
        a8 = 8'hFF; b8 = 8'h00; cin8 = 1'b0; start8 = 1'b1;
        q8.push_back(9'h0FF);
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("partial_s8_before_abort", {busy8, s8}, {1'b1, 8'hE0});
        #2 rst_n = 1'b0;
        #1;
        check("abort8_async_outputs", {busy8, done8, cout8, s8}, 0);
        void'(q8.pop_back());
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (12) @(posedge clk);

        add8(8'hC3, 8'h3C, 1'b1);
        repeat (20) add8(8'($urandom), 8'($urandom), 1'($urandom));

        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("hold8_stable", {busy8, done8, cout8, s8}, {2'b00, last8});
        end

        // N=2 exhaustive with start held high: back-to-back adds every N+2 cycles.
        @(posedge clk); #1;
        start2 = 1'b1;
        prev = 0;
        for (int i = 0; i < 32; i++) begin
            a2 = i[4:3]; b2 = i[2:1]; cin2 = i[0];
            q2.push_back(3'(i[4:3]) + 3'(i[2:1]) + 3'(i[0]));
            got = 0;
            for (int k = 0; k < 20 && !got; k++) begin
                @(posedge clk); #1;
                if (done2) got = 1;
            end
            check("done2_timeout", got, 1);
            if (i > 0) check("spacing2", cyc - prev, 4);
            prev = cyc;
        end
        start2 = 1'b0;

        repeat (6) @(posedge clk);
        check("q8_drained", q8.size(), 0);
        check("q2_drained", q2.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
